wb_writer: RTL and testbench

- Write-side companion to the 32x32 register file: collects results from the single-cycle ALU path and the multi-cycle load/store unit (LSU), and drives the register file write port (we, A3, WD).
- A DEPTH-entry FIFO buffers LSU results; the ALU path has write priority.
- A per-register pending-load scoreboard gives the issue stage a hazard flag, so no instruction reads or overwrites a register with a load still outstanding.

---
 rtl/wb_writer_if.sv | 32 +++
 rtl/wb_writer.sv | 87 ++++++++
 tb/tb_wb_writer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_writer_if.sv
// Signal bundle between the core (issue/ALU/LSU) and the register-file write-back block.
interface wb_writer_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        iss_load;
  logic [4:0]  iss_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic [4:0]  q_rd;
  logic        hz;
  logic        alu_stall;
  logic        we;
  logic [4:0]  A3;
  logic [31:0] WD;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           iss_load, iss_rd, q_rs1, q_rs2, q_rd,
    input  lsu_ready, hz, alu_stall, we, A3, WD
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           iss_load, iss_rd, q_rs1, q_rs2, q_rd,
    output lsu_ready, hz, alu_stall, we, A3, WD
  );
endinterface

// File: rtl/wb_writer.sv
// Register-file write arbiter: ALU results win, LSU results queue in a FIFO,
// and a per-register pending-load scoreboard drives the issue hazard flag.
module wb_writer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic        clk,
  input  logic        res_n,
  wb_writer_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]       fifo_rd   [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic [CNT_W-1:0] cnt [32];

  logic        alu_sel, push, pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign bus.lsu_ready = (count != CW'(DEPTH));

  always_comb begin
    alu_sel   = bus.alu_valid && (bus.alu_rd != '0);
    push      = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != '0);
    pop       = !alu_sel && (count != '0);
    head_rd   = fifo_rd[rd_ptr];
    head_data = fifo_data[rd_ptr];
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    bus.hz = ((bus.q_rs1 != '0) && (cnt[bus.q_rs1] != '0)) ||
             ((bus.q_rs2 != '0) && (cnt[bus.q_rs2] != '0)) ||
             ((bus.q_rd  != '0) && (cnt[bus.q_rd]  != '0));
  end

  // Payload storage needs no reset: an entry is only read after it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.lsu_rd;
      fifo_data[wr_ptr] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.alu_stall <= 1'b0;
      bus.we        <= 1'b0;
      bus.A3        <= '0;
      bus.WD        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count         <= count_nxt;
      bus.alu_stall <= (count_nxt >= CW'(DEPTH - 1));
      bus.we        <= alu_sel || pop;
      if (alu_sel) begin
        bus.A3 <= bus.alu_rd;
        bus.WD <= bus.alu_data;
      end else if (pop) begin
        bus.A3 <= head_rd;
        bus.WD <= head_data;
      end
    end
  end

  // Simultaneous issue and retire of the same register cancel out.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int unsigned i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        if ((bus.iss_load && (bus.iss_rd == 5'(i))) && !(pop && (head_rd == 5'(i))))
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!(bus.iss_load && (bus.iss_rd == 5'(i))) && (pop && (head_rd == 5'(i))))
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_wb_writer.sv
// Self-checking bench for wb_writer: queue-based reference model plus directed and random traffic.
module tb_wb_writer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic res_n;
  wb_writer_if bus();

  wb_writer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .res_n(res_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, counters as plain ints.
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  int          mcnt[32];
  logic        e_we, e_stall;
  logic [4:0]  e_a3;
  logic [31:0] e_wd;

  always @(posedge clk or negedge res_n) begin
    bit   rdy;
    ent_t h;
    if (!res_n) begin
      mq.delete();
      foreach (mcnt[i]) mcnt[i] = 0;
      e_we = 0; e_a3 = '0; e_wd = '0; e_stall = 0;
    end else begin
      rdy = (mq.size() != DEPTH);
      if (bus.alu_valid && bus.alu_rd != 0) begin
        e_we = 1; e_a3 = bus.alu_rd; e_wd = bus.alu_data;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        e_we = 1; e_a3 = h.rd; e_wd = h.data;
        assert (mcnt[h.rd] > 0) else $error("scoreboard decrement at zero for r%0d", h.rd);
        mcnt[h.rd]--;
      end else begin
        e_we = 0;
      end
      if (bus.lsu_valid && rdy && bus.lsu_rd != 0) mq.push_back('{bus.lsu_rd, bus.lsu_data});
      if (bus.iss_load && bus.iss_rd != 0) begin
        assert (mcnt[bus.iss_rd] < CMAX) else $error("scoreboard increment at max for r%0d", bus.iss_rd);
        mcnt[bus.iss_rd]++;
      end
      e_stall = (mq.size() >= DEPTH - 1);
    end
  end

  function automatic bit model_hz();
    return (bus.q_rs1 != 0 && mcnt[bus.q_rs1] != 0) ||
           (bus.q_rs2 != 0 && mcnt[bus.q_rs2] != 0) ||
           (bus.q_rd  != 0 && mcnt[bus.q_rd]  != 0);
  endfunction

  always @(negedge clk) begin
    chk("we", bus.we, e_we);
    chk("A3", bus.A3, e_a3);
    chk("WD", bus.WD, e_wd);
    chk("alu_stall", bus.alu_stall, e_stall);
    chk("lsu_ready", bus.lsu_ready, mq.size() != DEPTH);
    chk("hz", bus.hz, model_hz());
  end

  always @(posedge clk)
    if (res_n) assert (!(bus.alu_valid && bus.alu_stall)) else $error("alu_valid asserted during alu_stall");

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.iss_load = 0; bus.iss_rd = '0;
    bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_we"}, bus.we, 0);
    chk({tag, "_A3"}, bus.A3, 0);
    chk({tag, "_WD"}, bus.WD, 0);
    chk({tag, "_stall"}, bus.alu_stall, 0);
    chk({tag, "_ready"}, bus.lsu_ready, 1);
    chk({tag, "_hz"}, bus.hz, 0);
  endtask

  logic [4:0] pend[$];
  logic [4:0] order[$];
  logic [31:0] odata[$];

  initial begin
    idle();
    res_n = 0;
    repeat (3) @(posedge clk);
    #3;
    bus.q_rs1 = 5'd7;
    #1 check_cleared("reset");
    bus.q_rs1 = '0;
    @(negedge clk); res_n = 1;
    step();

    // ALU single write
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    step();
    chk("alu_we", bus.we, 1); chk("alu_A3", bus.A3, 5); chk("alu_WD", bus.WD, 32'hDEADBEEF);
    bus.alu_valid = 0;
    step();
    chk("alu_we_off", bus.we, 0); chk("alu_A3_hold", bus.A3, 5);

    // Load to r7 with hazard
    bus.iss_load = 1; bus.iss_rd = 5'd7; bus.q_rs1 = 5'd7;
    step();
    bus.iss_load = 0;
    #1 chk("ld7_hz", bus.hz, 1);
    bus.lsu_valid = 1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h1234;
    step();
    bus.lsu_valid = 0;
    chk("ld7_nowrite", bus.we, 0);
    step();
    chk("ld7_we", bus.we, 1); chk("ld7_A3", bus.A3, 7); chk("ld7_WD", bus.WD, 32'h1234);
    step();
    chk("ld7_hz_clear", bus.hz, 0);
    idle();

    // FIFO fill under ALU traffic, drain in order
    for (int k = 1; k <= 4; k++) begin
      bus.iss_load = 1; bus.iss_rd = 5'(k);
      step();
    end
    bus.iss_load = 0;
    for (int k = 1; k <= 4; k++) begin
      bus.lsu_valid = 1; bus.lsu_rd = 5'(k); bus.lsu_data = 32'h100 + k;
      bus.alu_valid = !e_stall; bus.alu_rd = 5'd10; bus.alu_data = k;
      step();
      if (k == 3) chk("fill_stall", bus.alu_stall, 1);
      if (bus.we && bus.A3 >= 1 && bus.A3 <= 4) begin order.push_back(bus.A3); odata.push_back(bus.WD); end
    end
    idle();
    for (int c = 0; c < 10 && order.size() < 4; c++) begin
      step();
      if (bus.we && bus.A3 >= 1 && bus.A3 <= 4) begin order.push_back(bus.A3); odata.push_back(bus.WD); end
    end
    chk("drain_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      chk("drain_rd", order[k], k + 1);
      chk("drain_data", odata[k], 32'h101 + k);
    end

    // Two loads to r9
    bus.q_rs2 = 5'd9;
    bus.iss_load = 1; bus.iss_rd = 5'd9;
    step(); step();
    bus.iss_load = 0;
    #1 chk("r9_hz2", bus.hz, 1);
    bus.lsu_valid = 1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'hA;
    step();
    bus.lsu_valid = 0;
    step();
    chk("r9_w1", bus.A3, 9); chk("r9_hz1", bus.hz, 1);
    bus.lsu_valid = 1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'hB;
    step();
    bus.lsu_valid = 0;
    chk("r9_hz_pending", bus.hz, 1);
    step();
    chk("r9_w2_we", bus.we, 1); chk("r9_w2_WD", bus.WD, 32'hB); chk("r9_hz0", bus.hz, 0);
    idle();

    // Register 0 traffic is discarded
    bus.alu_valid = 1; bus.alu_rd = '0; bus.alu_data = 32'h55;
    bus.lsu_valid = 1; bus.lsu_rd = '0; bus.lsu_data = 32'h66;
    bus.iss_load = 1; bus.iss_rd = '0;
    #1 chk("r0_ready", bus.lsu_ready, 1);
    step();
    idle();
    chk("r0_we", bus.we, 0);
    step();
    chk("r0_we2", bus.we, 0);

    // Async reset with three queued entries
    for (int k = 1; k <= 3; k++) begin
      bus.iss_load = 1; bus.iss_rd = 5'(k);
      step();
    end
    bus.iss_load = 0;
    for (int k = 1; k <= 3; k++) begin
      bus.lsu_valid = 1; bus.lsu_rd = 5'(k); bus.lsu_data = 32'h200 + k;
      bus.alu_valid = 1; bus.alu_rd = 5'd11; bus.alu_data = 32'hF0 + k;
      step();
    end
    idle();
    chk("pre_rst_stall", bus.alu_stall, 1);
    bus.q_rs1 = 5'd2;
    #1 res_n = 0;
    #1 check_cleared("async_rst");
    @(negedge clk); res_n = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_we", bus.we, 0);
    end

    // Randomized traffic
    pend.delete();
    for (int c = 0; c < 3000; c++) begin
      int r;
      bus.alu_valid = !e_stall && ($urandom_range(0, 1) == 1);
      bus.alu_rd = 5'($urandom_range(0, 7));
      bus.alu_data = $urandom;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.lsu_valid = 1; bus.lsu_rd = pend[0]; bus.lsu_data = $urandom;
        if (mq.size() != DEPTH) void'(pend.pop_front());
      end else begin
        bus.lsu_valid = ($urandom_range(0, 15) == 0); bus.lsu_rd = '0; bus.lsu_data = $urandom;
      end
      r = $urandom_range(0, 7);
      bus.iss_load = 0;
      if ($urandom_range(0, 2) == 0 && (r == 0 || mcnt[r] < CMAX)) begin
        bus.iss_load = 1; bus.iss_rd = 5'(r);
        if (r != 0) pend.push_back(5'(r));
      end
      bus.q_rs1 = 5'($urandom_range(0, 7));
      bus.q_rs2 = 5'($urandom_range(0, 7));
      bus.q_rd  = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
